mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one N-to-1 mux datapath and a single registered output port among `NUM_REQ` valid/ready requesters. Each cycle it picks one requester, steers its data through the select path into a one-beat output register, and reports the winning index on `grant_sel`. It sits in front of the `mux_2to1`/`mux_4to1`/`mux_8to1` family as its sequencing controller and turns a static select into a fair, back-pressured shared channel.

---
 rtl/mux_rr_arbiter_pkg.sv | 27 ++
 rtl/mux_rr_arbiter_if.sv | 37 +++
 rtl/mux_rr_arbiter_rr_pick.sv | 52 +++++
 rtl/mux_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// ============================================================================
// Module      : mux_arb_pkg
// Description : Shared types and helpers for the round-robin mux arbiter.
//               Build option MUX_ARB_LOCK_EN enables packet lock in the top.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_arb_pkg;

  // Arbitration state: per-beat arbitration or locked to one packet owner
  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int c_NUM_REQ_DEFAULT = 4;
  localparam int c_DATA_W_DEFAULT  = 2;

  // Increment an index and wrap it back to zero at n
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_rr_arbiter_if.sv
// ============================================================================
// Module      : mux_rr_arbiter_if
// Description : Requester-side and output-side handshake bundle of the
//               round-robin mux arbiter. slave = arbiter, master = environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mux_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 2
);
  localparam int SEL_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;
  logic                      out_ready;
  logic [SEL_W-1:0]          grant_sel;

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, grant_sel
  );

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, grant_sel
  );

endinterface

`default_nettype wire

// File: rtl/mux_rr_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Finds the first valid
//               requester at or above the pointer (wrapping), or returns the
//               forced index when a packet owner is locked in.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = $clog2(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] i_req_valid,
  input  wire logic [SEL_W-1:0]   i_ptr,
  input  wire logic               i_force_en,
  input  wire logic [SEL_W-1:0]   i_force_idx,
  output logic      [SEL_W-1:0]   o_win,
  output logic                    o_any
);

  // Search from highest offset down so the nearest valid requester wins last
  always_comb begin
    o_win = i_ptr;
    o_any = 1'b0;
    if (i_force_en) begin
      o_win = i_force_idx;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i_force_idx == SEL_W'(i)) begin
          o_any = i_req_valid[i];
        end
      end
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        int unsigned idx;
        idx = 32'(i_ptr) + 32'(k);
        if (idx >= 32'(NUM_REQ)) begin
          idx = idx - 32'(NUM_REQ);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if ((idx == 32'(i)) && i_req_valid[i]) begin
            o_win = SEL_W'(i);
            o_any = 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Round-robin arbiter sharing one N:1 data mux and a one-beat
//               registered output among NUM_REQ valid/ready requesters.
//               Optional packet lock: define MUX_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int NUM_REQ = c_NUM_REQ_DEFAULT,
  parameter int DATA_W  = c_DATA_W_DEFAULT
) (
  input wire logic          clk,
  input wire logic          rst_n,
  mux_rr_arbiter_if.slave   bus
);

  localparam int SEL_W = $clog2(NUM_REQ);

  logic [SEL_W-1:0]   r_ptr;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_last;
  logic [SEL_W-1:0]   r_grant_sel;

  logic [SEL_W-1:0]   w_win;
  logic               w_any;
  logic               w_can_accept;
  logic               w_accept;
  logic               w_force_en;
  logic [SEL_W-1:0]   w_force_idx;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_sel_last;
  logic [NUM_REQ-1:0] w_req_ready;

`ifdef MUX_ARB_LOCK_EN
  arb_state_e         r_state;
  logic [SEL_W-1:0]   r_owner;

  assign w_force_en  = (r_state == LOCK);
  assign w_force_idx = r_owner;
`else
  assign w_force_en  = 1'b0;
  assign w_force_idx = '0;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_pick (
    .i_req_valid (bus.req_valid),
    .i_ptr       (r_ptr),
    .i_force_en  (w_force_en),
    .i_force_idx (w_force_idx),
    .o_win       (w_win),
    .o_any       (w_any)
  );

  // The output register can take a beat when empty or being drained this cycle
  assign w_can_accept = !r_out_valid || bus.out_ready;
  // w_any already implies the winner itself is valid
  assign w_accept     = w_can_accept && w_any;

  // One-hot ready to the winner only; held low while reset is asserted
  always_comb begin
    w_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req_ready[i] = rst_n && w_accept && (w_win == SEL_W'(i));
    end
  end

  // Data/last select path steered by the winning index
  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == SEL_W'(i)) begin
        w_sel_data = bus.req_data[i*DATA_W +: DATA_W];
        w_sel_last = bus.req_last[i];
      end
    end
  end

  // Output register, round-robin pointer and lock state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_grant_sel <= '0;
      r_ptr       <= '0;
`ifdef MUX_ARB_LOCK_EN
      r_state     <= ARB;
      r_owner     <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_last  <= w_sel_last;
        r_grant_sel <= w_win;
        // In LOCK the winner is the owner, so this also yields owner+1
        r_ptr       <= SEL_W'(wrap_inc(32'(w_win), NUM_REQ));
`ifdef MUX_ARB_LOCK_EN
        case (r_state)
          ARB: begin
            if (!w_sel_last) begin
              r_owner <= w_win;
              r_state <= LOCK;
            end
          end
          LOCK: begin
            if (w_sel_last) begin
              r_state <= ARB;
            end
          end
          default: r_state <= ARB;
        endcase
`endif
      end else if (bus.out_ready) begin
        // Drain with nothing to reload; data and grant hold their values
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.grant_sel = r_grant_sel;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
// ============================================================================
// Module      : tb_mux_rr_arbiter
// Description : Self-checking bench for mux_rr_arbiter with a behavioural
//               reference model; follows MUX_ARB_LOCK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  mux_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int m_ptr;
  int m_ov;
  int m_data;
  int m_last;
  int m_sel;
  int m_lock;
  int m_owner;
  int m_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_ov = 0; m_data = 0; m_last = 0; m_sel = 0;
    m_lock = 0; m_owner = 0; m_acc = -1;
  endtask

  // Winner: the locked owner, else the first valid index scanning up from ptr
  task automatic model_pick(output int win, output int any);
    win = 0; any = 0;
    if (m_lock != 0) begin
      win = m_owner;
      any = int'(bus.req_valid[m_owner]);
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (bus.req_valid[(m_ptr + k) % N]) begin
          win = (m_ptr + k) % N;
          any = 1;
        end
      end
    end
  endtask

  task automatic check_outputs(input int exp_ready);
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    chk("out_data",  32'(bus.out_data),  32'(m_data));
    chk("out_last",  32'(bus.out_last),  32'(m_last));
    chk("grant_sel", 32'(bus.grant_sel), 32'(m_sel));
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge
  task automatic cycle();
    int win, any, can, exp_ready;
    @(negedge clk);
    model_pick(win, any);
    can = ((m_ov == 0) || bus.out_ready) ? 1 : 0;
    exp_ready = (rst_n && can != 0 && any != 0) ? (1 << win) : 0;
    check_outputs(exp_ready);
    @(posedge clk);
    m_acc = -1;
    if (!rst_n) begin
      model_reset();
    end else if (can != 0 && any != 0) begin
      m_ov   = 1;
      m_data = int'(bus.req_data[win*DW +: DW]);
      m_last = int'(bus.req_last[win]);
      m_sel  = win;
      m_acc  = win;
      m_ptr  = (win + 1) % N;
`ifdef MUX_ARB_LOCK_EN
      if (m_lock == 0 && m_last == 0) begin
        m_lock  = 1;
        m_owner = win;
      end else if (m_lock != 0 && m_last != 0) begin
        m_lock = 0;
      end
`endif
    end else if (bus.out_ready) begin
      m_ov = 0;
    end
    #1;
  endtask

  initial begin
    int beat;
    model_reset();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.out_ready = 1'b0;

    // Reset asserted: everything at reset values
    #12;
    check_outputs(0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle after release, nothing valid
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) cycle();

    // All four valid with distinct data: grants rotate 0,1,2,3,0
    bus.req_valid = 4'b1111;
    bus.req_data  = {2'd3, 2'd2, 2'd1, 2'd0};
    bus.req_last  = 4'b1111;
    for (int c = 0; c < 6; c++) cycle();

    // Only requester 2, data 2'b10: accepted every cycle
    bus.req_valid = 4'b0100;
    for (int c = 0; c < 4; c++) cycle();

    // Stall with requesters 0 and 1 waiting
    bus.req_valid = 4'b0011;
    cycle();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) cycle();

    // Asynchronous reset mid-stream
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 2; c++) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(0);
    cycle();
    rst_n = 1'b1;
    bus.req_valid = 4'b0110;
    for (int c = 0; c < 2; c++) cycle();

    // Packet from requester 1 (last=0,0,1) competing with requester 0
    bus.req_valid = 4'b0001;
    bus.req_last  = 4'b0001;
    cycle();
    bus.req_valid = 4'b0011;
    bus.req_data[1*DW +: DW] = 2'd1;
    bus.req_last[1] = 1'b0;
    beat = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (m_acc == 1) begin
        beat++;
        if (beat >= 3) begin
          bus.req_valid[1] = 1'b0;
        end else begin
          bus.req_data[1*DW +: DW] = 2'(beat + 1);
          bus.req_last[1] = (beat == 2);
        end
      end
      if (m_acc == 0) bus.req_data[0*DW +: DW] = 2'($urandom);
    end

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] || m_acc == i) begin
          bus.req_valid[i] = ($urandom_range(0, 2) != 0);
          bus.req_data[i*DW +: DW] = 2'($urandom);
          bus.req_last[i] = ($urandom_range(0, 2) == 0);
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
